info_bus_gen: RTL and testbench
===============================

# info_bus_gen

Head of the climber video pipeline. Generates 1024x768@60 Hz XVGA timing at 65 MHz and samples the hand tracker and the glove grab buttons once per frame. It packs everything into the 69-bit info bus consumed by the hold and grab stages. This block transmits the bus that every downstream stage unpacks and delays.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP / H_SYNC / H_BP, 24 / 136 / 160, horizontal porches and sync (total 1344)
- V_ACTIVE, 768, visible lines
- V_FP / V_SYNC / V_BP, 3 / 6 / 29, vertical porches and sync (total 806)
- DEBOUNCE_CYCLES, 650000, stable-input cycles before a grab button change is accepted (≈10 ms)

Ports:
- clockin  in  1  65 MHz pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- hand1x_in / hand2x_in  in  11  tracker hand x, any value
- hand1y_in / hand2y_in  in  10  tracker hand y, any value
- grab1_raw / grab2_raw  in  1  glove buttons, asynchronous, 1 = closed
- infout  out  69  info bus: [68] reset, [67:57] hcount, [56:47] vcount, [46] hsync, [45] vsync, [44] blank, [43:33] hand1x, [32:23] hand1y, [22:12] hand2x, [11:2] hand2y, [1] grab2, [0] grab1
- existsout  out  1  constant 0 (no hold at the pipeline head)
- clockout  out  1  equals clockin, combinational passthrough

## Operation
- hcount counts 0..1343 and wraps to 0. On wrap, vcount increments over 0..805 and wraps to 0.
- blank = 1 when hcount ≥ 1024 or vcount ≥ 768.
- hsync = 0 (active-low) for hcount 1048..1183. vsync = 0 for vcount 771..776. Otherwise both are 1.
- Frame start is the cycle where the counters move from (1343,805) to (0,0). On that edge the hand registers load:
  - x is clamped to 1023 if it is above 1023.
  - y is clamped to 767 if it is above 767.
  - The loaded values are held constant for the whole frame.
- Grab path, per button:
  - 2-FF synchronizer, then the grab_debounce counter.
  - The counter resets whenever the synced input differs from the accepted value.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted value takes the input.
  - Accepted values are latched onto bus bits [1:0] at frame start only.
- Bus reset bit [68]:
  - 1 while reset_n is low.
  - Stays 1 after release until the first frame start, and is 0 from that bus word onward.
- All infout fields are registered together, so a bus word is always self-consistent.

## Timing
- Async reset values:
  - hcount = 0, vcount = 0, hsync = 1, vsync = 1, blank = 0.
  - Hand fields = 0, grabs = 0, bus reset bit = 1.
  - Debounce counters = 0, accepted = 0, existsout = 0.
- After reset_n rises, the first clock edge produces hcount = 1. The counters run continuously.
- Latency: infout shows the counter state one cycle after it is computed. Sync and blank are registered with it, so no extra skew.
- Hand sample latency: a tracker value present at the frame-start edge appears in the bus word carrying (0,0). It stays until the next (0,0) word.
- Grab latency:
  - Raw edge to accepted value: 2 + DEBOUNCE_CYCLES cycles.
  - It then waits for the next frame start, up to 1083264 cycles.
- Input glitches shorter than DEBOUNCE_CYCLES are ignored.
- Reset mid-frame: all outputs return to reset values asynchronously. The frame restarts at (0,0) after release. No partial hand update survives.
- Simultaneous events:
  - A grab accept and a frame start on the same edge: the new accepted value is used.
  - A tracker change on the frame-start edge: the value present at that edge is used.

## Structure
- Shared package climber_pkg:
  - Timing constants (H/V totals, sync start/end).
  - Bus field offsets and widths (INFO_W = 69).
  - Clamp limits.
- Sub-module grab_debounce: synchronizer plus counter, parameter DEBOUNCE_CYCLES, output accepted. Instantiated twice.
- Counters, sync decode, clamp and bus packing stay in the top level.

## Test plan
- Release reset, run 2 frames (DEBOUNCE_CYCLES = 16 for sim) -> hcount wraps at 1343, vcount wraps at 805.
- Same run, sync timing -> hsync low exactly on hcount 1048..1183, vsync low exactly on vcount 771..776, blank matches the visible-area rule.
- Same run, bus reset bit -> [68] = 1 until the first (0,0) word, 0 afterward.
- Drive hand1x = 500, hand1y = 300; change to 600, 400 mid-frame -> bus holds 500/300 until the next (0,0) word, then shows 600/400.
- Drive hand2x = 2000, hand2y = 900 -> bus shows 1023 / 767.
- Grab input tests:
  - 10-cycle pulse on grab1_raw -> bus bit [0] stays 0.
  - Hold grab1_raw for 40 cycles -> bit [0] = 1 from the next frame start.
- Assert reset_n low at vcount 400 -> infout returns to reset values immediately. After release, the bus resumes from (0,0) with [68] = 1 for that first frame.

Source files
------------

// File: rtl/climber_pkg.sv
// Shared definitions for the climber video pipeline: XVGA timing defaults,
// info bus layout and tracker clamp limits.
package climber_pkg;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;
  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;
  localparam int DEBOUNCE_DEF = 650000;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int INFO_W = 69;

  localparam logic [X_W-1:0] X_MAX = 11'd1023;
  localparam logic [Y_W-1:0] Y_MAX = 10'd767;

  // Field order is the bus layout, MSB first.
  typedef struct packed {
    logic           rst;
    logic [X_W-1:0] hcount;
    logic [Y_W-1:0] vcount;
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic [X_W-1:0] hand1x;
    logic [Y_W-1:0] hand1y;
    logic [X_W-1:0] hand2x;
    logic [Y_W-1:0] hand2y;
    logic           grab2;
    logic           grab1;
  } info_bus_t;

  localparam info_bus_t BUS_RESET = info_bus_t'({1'b1, 21'd0, 2'b11, 1'b0, 42'd0, 2'b00});

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

endpackage

// File: rtl/grab_debounce.sv
// Glove button conditioner: two-flop synchronizer followed by a stability
// counter; the accepted level only changes after a long enough stable run.
module grab_debounce #(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clockin,
  input  logic reset_n,
  input  logic raw,
  output logic accepted,
  output logic accept_now
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // accept_now marks the edge on which accepted flips to the synced level.
  always_comb begin
    cnt_nxt    = '0;
    accept_now = 1'b0;
    if (sync2 != accepted) begin
      if (cnt == CNT_LAST) accept_now = 1'b1;
      else                 cnt_nxt    = cnt + 1'b1;
    end
  end

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      accepted <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      cnt      <= cnt_nxt;
      accepted <= accepted ^ accept_now;
    end
  end

endmodule

// File: rtl/info_bus_gen.sv
// Pipeline head: XVGA timing counters, per-frame tracker/grab sampling and
// packing of the registered 69-bit info bus.
module info_bus_gen
  import climber_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_FP            = H_FP_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BP            = H_BP_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_FP            = V_FP_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BP            = V_BP_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic              clockin,
  input  logic              reset_n,
  input  logic [X_W-1:0]    hand1x_in,
  input  logic [Y_W-1:0]    hand1y_in,
  input  logic [X_W-1:0]    hand2x_in,
  input  logic [Y_W-1:0]    hand2y_in,
  input  logic              grab1_raw,
  input  logic              grab2_raw,
  output logic [INFO_W-1:0] infout,
  output logic              existsout,
  output logic              clockout
);

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [X_W-1:0] H_VIS    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [Y_W-1:0] V_VIS    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  info_bus_t      bus_q;
  info_bus_t      bus_d;
  logic           g1_acc, g1_take;
  logic           g2_acc, g2_take;
  logic           h_wrap;
  logic           frame_start;
  logic [X_W-1:0] h_nxt;
  logic [Y_W-1:0] v_nxt;

  grab_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_grab1 (
    .clockin    (clockin),
    .reset_n    (reset_n),
    .raw        (grab1_raw),
    .accepted   (g1_acc),
    .accept_now (g1_take)
  );

  grab_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_grab2 (
    .clockin    (clockin),
    .reset_n    (reset_n),
    .raw        (grab2_raw),
    .accepted   (g2_acc),
    .accept_now (g2_take)
  );

  assign h_wrap      = (bus_q.hcount == H_LAST);
  assign frame_start = h_wrap && (bus_q.vcount == V_LAST);

  // Sync and blank are decoded from the next counts so they land in the
  // same bus word as the counts they describe.
  always_comb begin
    h_nxt = h_wrap ? '0 : bus_q.hcount + 1'b1;
    v_nxt = bus_q.vcount;
    if (h_wrap) v_nxt = (bus_q.vcount == V_LAST) ? '0 : bus_q.vcount + 1'b1;

    bus_d        = bus_q;
    bus_d.hcount = h_nxt;
    bus_d.vcount = v_nxt;
    bus_d.hsync  = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
    bus_d.vsync  = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
    bus_d.blank  = (h_nxt >= H_VIS) || (v_nxt >= V_VIS);

    // A grab accepted on the frame-start edge already counts for this frame.
    if (frame_start) begin
      bus_d.rst    = 1'b0;
      bus_d.hand1x = clamp_x(hand1x_in);
      bus_d.hand1y = clamp_y(hand1y_in);
      bus_d.hand2x = clamp_x(hand2x_in);
      bus_d.hand2y = clamp_y(hand2y_in);
      bus_d.grab1  = g1_acc ^ g1_take;
      bus_d.grab2  = g2_acc ^ g2_take;
    end
  end

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) bus_q <= BUS_RESET;
    else          bus_q <= bus_d;
  end

  assign infout    = bus_q;
  assign existsout = 1'b0;
  assign clockout  = clockin;

endmodule

// File: tb/tb_info_bus_gen.sv
// Directed bench: a shrunken-timing instance exercises frames, sampling and
// debounce; a default-timing instance covers the real horizontal timing.
module tb_info_bus_gen;
  import climber_pkg::*;

  localparam int S_HT    = 32;
  localparam int S_VT    = 18;
  localparam int S_FRAME = 576;
  localparam int F_HT    = 1344;

  logic        clockin = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hand1x_in, hand2x_in;
  logic [9:0]  hand1y_in, hand2y_in;
  logic        grab1_raw, grab2_raw;
  logic [68:0] inf_s, inf_f;
  logic        ex_s, ex_f, ck_s, ck_f;
  int          tests = 0;
  int          fails = 0;

  always #5 clockin = ~clockin;

  info_bus_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .DEBOUNCE_CYCLES(16)
  ) dut_s (
    .clockin(clockin), .reset_n(reset_n),
    .hand1x_in(hand1x_in), .hand1y_in(hand1y_in),
    .hand2x_in(hand2x_in), .hand2y_in(hand2y_in),
    .grab1_raw(grab1_raw), .grab2_raw(grab2_raw),
    .infout(inf_s), .existsout(ex_s), .clockout(ck_s)
  );

  info_bus_gen dut_f (
    .clockin(clockin), .reset_n(reset_n),
    .hand1x_in(hand1x_in), .hand1y_in(hand1y_in),
    .hand2x_in(hand2x_in), .hand2y_in(hand2y_in),
    .grab1_raw(grab1_raw), .grab2_raw(grab2_raw),
    .infout(inf_f), .existsout(ex_f), .clockout(ck_f)
  );

  task automatic check(input string tag, input int n, input logic [68:0] got, input logic [68:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [68:0] pack(input logic r, input int h, input int v,
                                       input logic hs, input logic vs, input logic bl,
                                       input logic [10:0] h1x, input logic [9:0] h1y,
                                       input logic [10:0] h2x, input logic [9:0] h2y,
                                       input logic g2, input logic g1);
    logic [10:0] hc;
    logic [9:0]  vc;
    hc = 11'(h);
    vc = 10'(v);
    return {r, hc, vc, hs, vs, bl, h1x, h1y, h2x, h2y, g2, g1};
  endfunction

  // Small timing: hsync low 23..27, vsync low 12..14, visible 20x10.
  function automatic logic [68:0] exp_small(input int n, input bit second_run);
    int          h, v, fr;
    logic [10:0] h1x, h2x;
    logic [9:0]  h1y, h2y;
    logic        g1, g2;
    h  = n % S_HT;
    v  = (n / S_HT) % S_VT;
    fr = n / S_FRAME;
    h1x = '0; h1y = '0; h2x = '0; h2y = '0; g1 = 1'b0; g2 = 1'b0;
    if (!second_run) begin
      if (fr >= 1) begin h1x = 11'd500; h1y = 10'd300; h2x = 11'd1023; h2y = 10'd767; end
      if (fr >= 2) begin h1x = 11'd600; h1y = 10'd400; g1 = 1'b1; g2 = 1'b1; end
    end else if (fr >= 1) begin
      h1x = 11'd600; h1y = 10'd400; h2x = 11'd1023; h2y = 10'd767; g1 = 1'b1; g2 = 1'b1;
    end
    return pack(fr == 0, h, v, !(h >= 23 && h <= 27), !(v >= 12 && v <= 14),
                (h >= 20) || (v >= 10), h1x, h1y, h2x, h2y, g2, g1);
  endfunction

  // Default timing, never reaching a frame start within this bench.
  function automatic logic [68:0] exp_full(input int n);
    int h, v;
    h = n % F_HT;
    v = n / F_HT;
    return pack(1'b1, h, v, !(h >= 1048 && h <= 1183), !(v >= 771 && v <= 776),
                (h >= 1024) || (v >= 768), '0, '0, '0, '0, 1'b0, 1'b0);
  endfunction

  initial begin
    hand1x_in = 11'd500;  hand1y_in = 10'd300;
    hand2x_in = 11'd2000; hand2y_in = 10'd900;
    grab1_raw = 1'b0;     grab2_raw = 1'b0;

    repeat (3) @(negedge clockin);
    check("reset_word_s", 0, inf_s, exp_small(0, 1'b0));
    check("reset_word_f", 0, inf_f, exp_full(0));
    check("existsout_s", 0, {68'd0, ex_s}, 69'd0);
    check("clockout_low", 0, {68'd0, ck_s}, 69'd0);
    @(posedge clockin);
    #1;
    check("clockout_high", 0, {68'd0, ck_f}, 69'd1);
    check("reset_held_s", 0, inf_s, exp_small(0, 1'b0));
    @(negedge clockin);
    reset_n = 1'b1;

    // First run: glitch, held grab, mid-frame hand change, same-edge accept.
    for (int n = 1; n <= 1319; n++) begin
      @(negedge clockin);
      check("bus_s", n, inf_s, exp_small(n, 1'b0));
      check("bus_f", n, inf_f, exp_full(n));
      if (n == 100) grab1_raw = 1'b1;
      if (n == 110) grab1_raw = 1'b0;
      if (n == 700) grab1_raw = 1'b1;
      if (n == 800) begin hand1x_in = 11'd600; hand1y_in = 10'd400; end
      if (n == 1134) grab2_raw = 1'b1;
    end

    // Reset at hcount 7, vcount 5 of the third frame.
    reset_n = 1'b0;
    #1;
    check("async_reset_s", 0, inf_s, exp_small(0, 1'b1));
    check("async_reset_f", 0, inf_f, exp_full(0));
    check("existsout_f", 0, {68'd0, ex_f}, 69'd0);
    repeat (2) @(negedge clockin);
    check("reset_hold_s", 0, inf_s, exp_small(0, 1'b1));
    reset_n = 1'b1;

    for (int n = 1; n <= 1400; n++) begin
      @(negedge clockin);
      check("bus2_s", n, inf_s, exp_small(n, 1'b1));
      check("bus2_f", n, inf_f, exp_full(n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
